// File: rtl/fpu_pkg.sv
// fpu_pkg: field widths and status-bit indices shared by the FPU and its result queue.
package fpu_pkg;
    localparam int EXP_W        = 7;
    localparam int MAN_W        = 24;
    localparam int WORD_W       = 32;
    localparam int ST_EXACT     = 0;
    localparam int ST_OVERFLOW  = 1;
    localparam int ST_UNDERFLOW = 2;
    localparam int ST_INEXACT   = 3;
endpackage

// File: rtl/fpu_result_queue.sv
// fpu_result_queue: FIFO of FPU results; sticky exception flags enabled by FPU_RESQ_STICKY_EN.
module fpu_result_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WORD_W-1:0]        in_data,
    input  logic [3:0]               in_status,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W-1:0]        out_data,
    output logic [3:0]               out_status,
    output logic [$clog2(DEPTH):0]   count,
    output logic [3:0]               sticky_flags,
    input  logic                     clear_flags
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_W+3:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              push, pop;

    assign in_ready  = count < CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign {out_data, out_status} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= {in_data, in_status};
    end

`ifdef FPU_RESQ_STICKY_EN
    logic [3:0] new_flags;
    assign new_flags = {in_status[ST_INEXACT:ST_OVERFLOW], 1'b0};
    always_ff @(posedge clk) begin
        if (reset) sticky_flags <= '0;
        else if (clear_flags) sticky_flags <= push ? new_flags : 4'b0;
        else if (push) sticky_flags <= sticky_flags | new_flags;
    end
`else
    logic unused_clear;
    assign unused_clear = clear_flags;
    assign sticky_flags = '0;
`endif
endmodule

// File: doc/fpu_result_queue.md
FPU_RESULT_QUEUE -- requirements
Module: fpu_result_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of result entries; power of two, minimum 2.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  FPU result present on in_data/in_status.
REQ-005 The block SHALL have port in_data  input  32  FPU data_out word: sign [31], exponent [30:24], mantissa [23:0].
REQ-006 The block SHALL have port in_status  input  4  FPU status_out word.
REQ-007 The block SHALL have port in_ready  output  1  queue can accept a result.
REQ-008 The block SHALL have port out_valid  output  1  head entry present.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-010 The block SHALL have port out_data  output  32  head entry data.
REQ-011 The block SHALL have port out_status  output  4  head entry status.
REQ-012 The block SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 The block SHALL have port sticky_flags  output  4  accumulated exception flags.
REQ-014 The block SHALL have port clear_flags  input  1  clear sticky_flags.

Function
REQ-015 Status encoding SHALL be one-hot: bit0 EXACT, bit1 OVERFLOW, bit2 UNDERFLOW, bit3 INEXACT.
REQ-016 The block SHALL store in_status verbatim, without validation.
REQ-017 A push SHALL occur on a cycle with in_valid=1 and in_ready=1; it writes {in_data,in_status} at the write pointer.
REQ-018 A pop SHALL occur on a cycle with out_valid=1 and out_ready=1; it advances the read pointer.
REQ-019 in_ready SHALL be 1 exactly when count<DEPTH, with no same-cycle pass-through: a push is refused when full, even with a simultaneous pop.
REQ-020 out_valid SHALL be 1 exactly when count>0.
REQ-021 out_data/out_status SHALL be driven from registered storage at the read pointer and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 Latency SHALL be one cycle: an entry pushed at edge N is visible on out_* after edge N, including when the queue was empty.
REQ-023 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-024 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow below 0.
REQ-025 Output values while out_valid=0 SHALL be don't-care for consumers but SHALL be deterministic (last-read storage).

Reset
REQ-026 When reset=1 at a rising edge, pointers, count and sticky_flags SHALL become 0; consequently in_ready=1 and out_valid=0.
REQ-027 Reset SHALL take priority over push, pop and clear_flags in the same cycle; entries in flight SHALL be discarded.
REQ-028 Storage contents SHALL NOT require reset.

Configuration
REQ-029 Macro FPU_RESQ_STICKY_EN SHALL control the sticky-flag feature.
REQ-030 With FPU_RESQ_STICKY_EN defined, on each push sticky_flags[3:1] SHALL OR in in_status[3:1], and sticky_flags[0] SHALL remain 0.
REQ-031 With FPU_RESQ_STICKY_EN defined, clear_flags=1 SHALL zero sticky_flags; a simultaneous push SHALL leave only that push's flags.
REQ-032 Without FPU_RESQ_STICKY_EN, sticky_flags SHALL be constant 0, clear_flags SHALL be ignored, and no flag registers SHALL be inferred.

Structure
REQ-033 The shared package fpu_pkg SHALL hold the status bit index constants (ST_EXACT=0, ST_OVERFLOW=1, ST_UNDERFLOW=2, ST_INEXACT=3) and the field widths (EXP_W=7, MAN_W=24, WORD_W=32); the FPU and this block SHALL both import them.
REQ-034 The design SHALL be a single module with no sub-modules; storage SHALL be an internal array of {WORD_W+4}-bit entries.

Verification
REQ-035 Test: after reset, push 0x3F000000/0001 -> next cycle out_valid=1, out_data=0x3F000000, out_status=0001, count=1.
REQ-036 Test: DEPTH=4, push 5 results with out_ready=0 -> in_ready=0 after 4th; 5th not stored; count=4; drain yields first 4 in order.
REQ-037 Test: at full, assert in_valid and out_ready together -> pop only, count 4->3, pushed word absent.
REQ-038 Test: continuous push+pop for 10 cycles across pointer wrap -> count constant 1, in-order data, no loss.
REQ-039 Test (STICKY_EN): push statuses 1000, 0010, then clear_flags with push 0100 -> sticky 1000, 1010, then 0100; without macro sticky stays 0000.
REQ-040 Test: reset asserted with count=3 -> next cycle count=0, out_valid=0, in_ready=1, sticky_flags=0.
